// File: rtl/control_dispensador.sv
// Beverage dispenser sequencer: latches the menu selection on an act2 rising edge,
// then runs cup drop, pour, mix and ready phases with cup supervision and CLC abort.
module control_dispensador #(
  parameter int unsigned T_CUP  = 4,
  parameter int unsigned T_POUR = 8,
  parameter int unsigned T_MIX  = 6,
  parameter int unsigned CW     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       act2,
  input  logic       B1,
  input  logic       B2,
  input  logic       B3,
  input  logic       B4,
  input  logic       CLC,
  input  logic       sensor_vaso,
  output logic       vaso,
  output logic       bomba,
  output logic [3:0] valvula,
  output logic       mezclador,
  output logic       ocupado,
  output logic       listo,
  output logic       error
);

  localparam int unsigned SW = 4;
  localparam logic [CW-1:0] LD_CUP  = CW'(T_CUP - 1);
  localparam logic [CW-1:0] LD_POUR = CW'(T_POUR - 1);
  localparam logic [CW-1:0] LD_MIX  = CW'(T_MIX - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CUP  = 3'd1,
    S_POUR = 3'd2,
    S_MIX  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t        state, state_d;
  logic [SW-1:0] sel, sel_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          act2_q;
  logic [SW-1:0] b_in_c;
  logic          start_c;
  logic          onehot_c;
  logic          cnt_zero_c;

  assign b_in_c     = {B4, B3, B2, B1};
  assign start_c    = act2 & ~act2_q;
  assign onehot_c   = (b_in_c != '0) && ((b_in_c & (b_in_c - SW'(1))) == '0);
  assign cnt_zero_c = (cnt == '0);

  // Next-state, selection latch and phase counter; CLC outranks expiry and cup faults.
  always_comb begin
    state_d = state;
    sel_d   = sel;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (start_c) begin
          sel_d = b_in_c;
          if (onehot_c) begin
            state_d = S_CUP;
            cnt_d   = LD_CUP;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_CUP: begin
        if (CLC) begin
          state_d = S_IDLE;
        end else if (cnt_zero_c) begin
          if (sensor_vaso) begin
            state_d = S_POUR;
            cnt_d   = LD_POUR;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_POUR: begin
        if (CLC) begin
          state_d = S_IDLE;
        end else if (!sensor_vaso) begin
          state_d = S_ERR;
        end else if (cnt_zero_c) begin
          state_d = S_MIX;
          cnt_d   = LD_MIX;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_MIX: begin
        if (CLC) begin
          state_d = S_IDLE;
        end else if (!sensor_vaso) begin
          state_d = S_ERR;
        end else if (cnt_zero_c) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_DONE, S_ERR: begin
        if (CLC) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, edge detector and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sel       <= '0;
      cnt       <= '0;
      act2_q    <= 1'b0;
      vaso      <= 1'b0;
      bomba     <= 1'b0;
      valvula   <= '0;
      mezclador <= 1'b0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      sel       <= sel_d;
      cnt       <= cnt_d;
      act2_q    <= act2;
      vaso      <= (state_d == S_CUP);
      bomba     <= (state_d == S_POUR);
      valvula   <= (state_d == S_POUR) ? sel_d : '0;
      mezclador <= (state_d == S_MIX);
      ocupado   <= (state_d == S_CUP) || (state_d == S_POUR) || (state_d == S_MIX);
      listo     <= (state_d == S_DONE);
      error     <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_control_dispensador.sv
// Randomized and directed bench for control_dispensador against a timeline reference
// model; runs a default-timing instance and an all-ones-timing instance side by side.
module tb_control_dispensador;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  typedef struct packed {
    int       mode;
    int       age;
    logic [3:0] sel;
    logic     prev;
  } mdl_t;

  logic clk, reset, act2, B1, B2, B3, B4, CLC, sensor_vaso;
  logic vaso0, bomba0, mez0, ocu0, listo0, err0;
  logic vaso1, bomba1, mez1, ocu1, listo1, err1;
  logic [3:0] valv0, valv1;
  logic [9:0] out0, out1;

  int   n_vec;
  int   n_err;
  mdl_t m0, m1;

  control_dispensador dut0 (
    .clk(clk), .reset(reset), .act2(act2), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .CLC(CLC), .sensor_vaso(sensor_vaso), .vaso(vaso0), .bomba(bomba0),
    .valvula(valv0), .mezclador(mez0), .ocupado(ocu0), .listo(listo0), .error(err0)
  );

  control_dispensador #(.T_CUP(1), .T_POUR(1), .T_MIX(1), .CW(8)) dut1 (
    .clk(clk), .reset(reset), .act2(act2), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .CLC(CLC), .sensor_vaso(sensor_vaso), .vaso(vaso1), .bomba(bomba1),
    .valvula(valv1), .mezclador(mez1), .ocupado(ocu1), .listo(listo1), .error(err1)
  );

  assign out0 = {vaso0, bomba0, valv0, mez0, ocu0, listo0, err0};
  assign out1 = {vaso1, bomba1, valv1, mez1, ocu1, listo1, err1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE;
    m.age  = 0;
    m.sel  = 4'd0;
    m.prev = 1'b0;
    return m;
  endfunction

  // One clock edge of the reference: elapsed time since start decides the phase.
  function automatic mdl_t mdl_step(input mdl_t m, input int tc, input int tp, input int tm,
                                    input logic a, input logic [3:0] b, input logic c,
                                    input logic s);
    mdl_t n;
    logic rise;
    n      = m;
    rise   = a & ~m.prev;
    n.prev = a;
    case (m.mode)
      M_IDLE: begin
        if (rise) begin
          n.sel = b;
          if ($countones(b) == 1) begin
            n.mode = M_RUN;
            n.age  = 0;
          end else begin
            n.mode = M_ERR;
          end
        end
      end
      M_RUN: begin
        if (c) n.mode = M_IDLE;
        else if (m.age < tc) begin
          if (m.age == tc - 1 && !s) n.mode = M_ERR;
          else n.age = m.age + 1;
        end else if (!s) n.mode = M_ERR;
        else n.age = m.age + 1;
        if (n.mode == M_RUN && n.age == tc + tp + tm) n.mode = M_DONE;
      end
      default: if (c) n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [9:0] mdl_out(input mdl_t m, input int tc, input int tp);
    logic run, v, bo, mz;
    logic [3:0] vl;
    run = (m.mode == M_RUN);
    v   = run && (m.age < tc);
    bo  = run && (m.age >= tc) && (m.age < tc + tp);
    mz  = run && (m.age >= tc + tp);
    vl  = bo ? m.sel : 4'd0;
    return {v, bo, vl, mz, run, m.mode == M_DONE, m.mode == M_ERR};
  endfunction

  task automatic drive(input logic a, input logic [3:0] b, input logic c, input logic s);
    @(negedge clk);
    check("out_t6", 32'(out0), 32'(mdl_out(m0, 4, 8)));
    check("out_t1", 32'(out1), 32'(mdl_out(m1, 1, 1)));
    act2 = a;
    {B4, B3, B2, B1} = b;
    CLC = c;
    sensor_vaso = s;
    m0 = mdl_step(m0, 4, 8, 6, a, b, c, s);
    m1 = mdl_step(m1, 1, 1, 1, a, b, c, s);
  endtask

  // Asserts reset between edges, checks the immediate drop, then releases it at a negedge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_t6", 32'(out0), 32'd0);
    check("arst_t1", 32'(out1), 32'd0);
    act2 = 1'b0;
    CLC = 1'b0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_t6", 32'(out0), 32'd0);
    reset = 1'b1;
    m0 = mdl_step(m0, 4, 8, 6, act2, {B4, B3, B2, B1}, CLC, sensor_vaso);
    m1 = mdl_step(m1, 1, 1, 1, act2, {B4, B3, B2, B1}, CLC, sensor_vaso);
  endtask

  task automatic to_idle();
    drive(1'b0, 4'b0000, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    int lat0, lat1;
    logic a;
    logic [3:0] b;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    act2 = 1'b0;
    {B4, B3, B2, B1} = 4'b0000;
    CLC = 1'b0;
    sensor_vaso = 1'b1;
    m0 = mdl_reset();
    m1 = mdl_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_t6", 32'(out0), 32'd0);
    check("reset_t1", 32'(out1), 32'd0);
    reset = 1'b1;

    // Nominal B3 sequence with measured latency to listo, then act2 held high.
    drive(1'b0, 4'b0100, 1'b0, 1'b1);
    drive(1'b1, 4'b0100, 1'b0, 1'b1);
    lat0 = -1;
    lat1 = -1;
    for (int i = 1; i <= 30; i++) begin
      drive(1'b1, 4'b0100, 1'b0, 1'b1);
      if (listo0 && lat0 < 0) lat0 = i - 1;
      if (listo1 && lat1 < 0) lat1 = i - 1;
    end
    check("lat_t6", 32'(lat0), 32'd18);
    check("lat_t1", 32'(lat1), 32'd3);
    drive(1'b1, 4'b0100, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b0100, 1'b0, 1'b1);
    check("no_retrig", 32'(ocu0), 32'd0);
    to_idle();

    // Invalid two-hot selection.
    drive(1'b1, 4'b0011, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'b0011, 1'b0, 1'b1);
    to_idle();

    // No cup at end of drop.
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) drive(1'b1, 4'b0001, 1'b0, 1'b0);
    to_idle();

    // Cup removed in third pour cycle.
    drive(1'b1, 4'b1000, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) drive(1'b1, 4'b1000, 1'b0, i != 7);
    to_idle();

    // CLC in second mix cycle, then held act2 and a fresh pulse.
    drive(1'b1, 4'b0010, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) drive(1'b1, 4'b0010, i == 14, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0010, 1'b0, 1'b1);
    drive(1'b0, 4'b0010, 1'b0, 1'b1);
    drive(1'b1, 4'b0010, 1'b0, 1'b1);
    for (int i = 0; i < 22; i++) drive(1'b1, 4'b0010, 1'b0, 1'b1);
    to_idle();

    // CLC coincident with pour expiry.
    drive(1'b1, 4'b0100, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) drive(1'b1, 4'b0100, i == 12, 1'b1);
    to_idle();

    // Async reset mid-pour.
    drive(1'b1, 4'b0001, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) drive(1'b1, 4'b0001, 1'b0, 1'b1);
    async_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 4'b0001, 1'b0, 1'b1);
    drive(1'b1, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 4'b0001, 1'b0, 1'b1);
    to_idle();

    // Randomized traffic.
    a = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 6) == 0) a = ~a;
      if ($urandom_range(0, 5) == 0) b = 4'($urandom);
      else b = 4'(1 << $urandom_range(0, 3));
      if (i % 700 == 350) async_reset();
      drive(a, b, $urandom_range(0, 24) == 0, $urandom_range(0, 30) != 0);
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
